// File: rtl/p12_cfg_sequencer.sv
// Command sequencer for the rotatable-tile array strobes (RUN, LOAD, COMMIT, READ).
// Define P12_READBACK_EN to build the READ path; without it op 3 is a one-cycle NOP.
module p12_cfg_sequencer #(
   parameter int CHAIN_LEN = 64,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [CW-1:0] cmd_arg,
   input  logic          wr_valid,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   output logic          rd_valid,
   output logic [7:0]    rd_data,
   input  logic          rd_ready,
   input  logic          tile_sc_out,
   output logic          ff_gate,
   output logic          l_gate,
   output logic          se,
   output logic          sc,
   output logic          lb,
   output logic          sel_v,
   output logic          sel_h,
   output logic          sel_d,
   output logic          busy
);

   localparam int NB    = (CHAIN_LEN + 7) / 8;
   localparam int LASTB = (CHAIN_LEN % 8 == 0) ? 8 : (CHAIN_LEN % 8);
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_RUN, S_LD_WAIT, S_LD_SHIFT, S_COMMIT, S_RD_SHIFT, S_RD_PUSH
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] run_cnt, run_cnt_nx;
   logic [BW-1:0] byte_idx, byte_idx_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    sh_byte, sh_byte_nx;
   logic [7:0]    rd_byte, rd_byte_nx;
   logic [2:0]    mask, mask_nx;
   logic          last_byte, last_bit;

   // The final byte only carries the chain-length remainder.
   assign last_byte = (byte_idx == BW'(NB - 1));
   assign last_bit  = last_byte ? (bit_cnt == 3'(LASTB - 1)) : (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         run_cnt  <= '0;
         byte_idx <= '0;
         bit_cnt  <= '0;
         sh_byte  <= '0;
         rd_byte  <= '0;
         mask     <= '0;
      end else begin
         state    <= state_nx;
         run_cnt  <= run_cnt_nx;
         byte_idx <= byte_idx_nx;
         bit_cnt  <= bit_cnt_nx;
         sh_byte  <= sh_byte_nx;
         rd_byte  <= rd_byte_nx;
         mask     <= mask_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      run_cnt_nx  = run_cnt;
      byte_idx_nx = byte_idx;
      bit_cnt_nx  = bit_cnt;
      sh_byte_nx  = sh_byte;
      rd_byte_nx  = rd_byte;
      mask_nx     = mask;
      cmd_ready   = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      rd_data     = 8'h00;
      ff_gate     = 1'b0;
      l_gate      = 1'b0;
      se          = 1'b0;
      sc          = 1'b0;
      lb          = 1'b1;
      sel_v       = 1'b0;
      sel_h       = 1'b0;
      sel_d       = 1'b0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  2'd0: begin
                     state_nx   = S_RUN;
                     run_cnt_nx = cmd_arg;
                  end
                  2'd1: begin
                     state_nx    = S_LD_WAIT;
                     byte_idx_nx = '0;
                  end
                  2'd2: begin
                     state_nx = S_COMMIT;
                     mask_nx  = cmd_arg[2:0];
                  end
                  default: begin
`ifdef P12_READBACK_EN
                     state_nx    = S_RD_SHIFT;
                     byte_idx_nx = '0;
                     bit_cnt_nx  = '0;
                     rd_byte_nx  = '0;
`else
                     // Zero-length RUN: one busy cycle, no strobes.
                     state_nx   = S_RUN;
                     run_cnt_nx = '0;
`endif
                  end
               endcase
            end
         end
         S_RUN: begin
            if (run_cnt != '0) begin
               ff_gate    = 1'b1;
               l_gate     = 1'b1;
               lb         = 1'b0;
               run_cnt_nx = run_cnt - CW'(1);
            end
            if (run_cnt == '0 || run_cnt == CW'(1))
               state_nx = S_IDLE;
         end
         S_LD_WAIT: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               sh_byte_nx = wr_data;
               bit_cnt_nx = '0;
               state_nx   = S_LD_SHIFT;
            end
         end
         S_LD_SHIFT: begin
            se         = 1'b1;
            ff_gate    = 1'b1;
            sc         = sh_byte[bit_cnt];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (last_bit) begin
               if (last_byte) begin
                  state_nx = S_IDLE;
               end else begin
                  byte_idx_nx = byte_idx + BW'(1);
                  state_nx    = S_LD_WAIT;
               end
            end
         end
         S_COMMIT: begin
            l_gate   = 1'b1;
            sel_v    = mask[2];
            sel_h    = mask[1];
            sel_d    = mask[0];
            state_nx = S_IDLE;
         end
`ifdef P12_READBACK_EN
         S_RD_SHIFT: begin
            // Recirculate so the chain is restored after CHAIN_LEN shifts.
            se                  = 1'b1;
            ff_gate             = 1'b1;
            sc                  = tile_sc_out;
            rd_byte_nx[bit_cnt] = tile_sc_out;
            bit_cnt_nx          = bit_cnt + 3'd1;
            if (last_bit)
               state_nx = S_RD_PUSH;
         end
         S_RD_PUSH: begin
            rd_valid = 1'b1;
            rd_data  = rd_byte;
            if (rd_ready) begin
               if (last_byte) begin
                  state_nx = S_IDLE;
               end else begin
                  byte_idx_nx = byte_idx + BW'(1);
                  bit_cnt_nx  = '0;
                  rd_byte_nx  = '0;
                  state_nx    = S_RD_SHIFT;
               end
            end
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

`ifndef P12_READBACK_EN
   logic unused_rd;
   assign unused_rd = ^{rd_ready, tile_sc_out, rd_byte};
`endif

endmodule
